// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the issue stage and the ALU: opcodes, ALU op codes,
// operand selects and the decoded control bundle.
package rv_pkg;

  localparam int XLEN     = 32;
  localparam int REG_ADDR = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    X_ZERO,
    X_RS1,
    X_PC
  } x_sel_e;

  typedef enum logic [1:0] {
    Y_ZERO,
    Y_RS2,
    Y_IMM
  } y_sel_e;

  typedef struct packed {
    alu_op_e alu_op;
    x_sel_e  x_sel;
    y_sel_e  y_sel;
    logic    wb_en;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    illegal;
  } ctrl_t;

  // Unsupported encodings compute 0 + 0 and have no side effects.
  localparam ctrl_t ILLEGAL_CTRL = '{
    alu_op:    ALU_ADD,
    x_sel:     X_ZERO,
    y_sel:     Y_ZERO,
    wb_en:     1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    branch:    1'b0,
    illegal:   1'b1
  };

  function automatic logic arith_f3_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
  endfunction

  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic sub);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = sub ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b010:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_issue_stage_if.sv
// Decode-to-ALU bundle: upstream instruction/operands, bypass, flush and the registered
// ALU-side outputs with their valid/ready handshake.
interface ex_issue_stage_if #(
  parameter int XLEN     = rv_pkg::XLEN,
  parameter int REG_ADDR = rv_pkg::REG_ADDR
);

  logic                in_valid;
  logic                in_ready;
  logic [31:0]         instr;
  logic [XLEN-1:0]     pc;
  logic [XLEN-1:0]     rs1_data;
  logic [XLEN-1:0]     rs2_data;
  logic [XLEN-1:0]     imm;
  logic                fwd_valid;
  logic [REG_ADDR-1:0] fwd_rd;
  logic [XLEN-1:0]     fwd_data;
  logic                flush;

  logic                out_valid;
  logic                out_ready;
  logic [3:0]          alu_op;
  logic [XLEN-1:0]     alu_x;
  logic [XLEN-1:0]     alu_y;
  logic [XLEN-1:0]     store_data;
  logic [REG_ADDR-1:0] rd;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                branch;
  logic                illegal;

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, imm,
    input  fwd_valid, fwd_rd, fwd_data, flush, out_ready,
    output in_ready, out_valid, alu_op, alu_x, alu_y, store_data,
    output rd, reg_write, mem_read, mem_write, branch, illegal
  );

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, imm,
    output fwd_valid, fwd_rd, fwd_data, flush, out_ready,
    input  in_ready, out_valid, alu_op, alu_x, alu_y, store_data,
    input  rd, reg_write, mem_read, mem_write, branch, illegal
  );

endinterface

// File: rtl/alu_control.sv
// Combinational RV32I decode: opcode/funct3/funct7[5] to ALU op, operand selects and
// memory/branch/writeback qualifiers.
module alu_control
  import rv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = ILLEGAL_CTRL;
    case (opcode_i)
      OPC_OP: begin
        if (arith_f3_legal(funct3_i)) begin
          ctrl_o.alu_op  = arith_op(funct3_i, funct7_5_i);
          ctrl_o.x_sel   = X_RS1;
          ctrl_o.y_sel   = Y_RS2;
          ctrl_o.wb_en   = 1'b1;
          ctrl_o.illegal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        // funct7 bit 30 is immediate data here, so ADDI never becomes SUB.
        if (arith_f3_legal(funct3_i)) begin
          ctrl_o.alu_op  = arith_op(funct3_i, 1'b0);
          ctrl_o.x_sel   = X_RS1;
          ctrl_o.y_sel   = Y_IMM;
          ctrl_o.wb_en   = 1'b1;
          ctrl_o.illegal = 1'b0;
        end
      end
      OPC_LOAD: begin
        ctrl_o.alu_op   = ALU_ADD;
        ctrl_o.x_sel    = X_RS1;
        ctrl_o.y_sel    = Y_IMM;
        ctrl_o.wb_en    = 1'b1;
        ctrl_o.mem_read = 1'b1;
        ctrl_o.illegal  = 1'b0;
      end
      OPC_STORE: begin
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.x_sel     = X_RS1;
        ctrl_o.y_sel     = Y_IMM;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.illegal   = 1'b0;
      end
      OPC_BRANCH: begin
        if ((funct3_i == 3'b000) || (funct3_i == 3'b001)) begin
          ctrl_o.alu_op  = ALU_SUB;
          ctrl_o.x_sel   = X_RS1;
          ctrl_o.y_sel   = Y_RS2;
          ctrl_o.branch  = 1'b1;
          ctrl_o.illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        ctrl_o.alu_op  = ALU_ADD;
        ctrl_o.x_sel   = X_ZERO;
        ctrl_o.y_sel   = Y_IMM;
        ctrl_o.wb_en   = 1'b1;
        ctrl_o.illegal = 1'b0;
      end
      OPC_AUIPC: begin
        ctrl_o.alu_op  = ALU_ADD;
        ctrl_o.x_sel   = X_PC;
        ctrl_o.y_sel   = Y_IMM;
        ctrl_o.wb_en   = 1'b1;
        ctrl_o.illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register feeding the ALU: decode, writeback bypass, operand select and a
// single-entry valid/ready register with flush.
module ex_issue_stage
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  ex_issue_stage_if.slave bus
);

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [REG_ADDR-1:0] rs1_idx;
  logic [REG_ADDR-1:0] rs2_idx;
  logic [REG_ADDR-1:0] rd_idx;
  logic                unused_instr_bits;
  ctrl_t               ctrl;

  assign opcode  = bus.instr[6:0];
  assign rd_idx  = bus.instr[11:7];
  assign funct3  = bus.instr[14:12];
  assign rs1_idx = bus.instr[19:15];
  assign rs2_idx = bus.instr[24:20];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:25]};

  alu_control u_alu_control (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7_5_i (bus.instr[30]),
    .ctrl_o     (ctrl)
  );

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] alu_x_d;
  logic [XLEN-1:0] alu_y_d;
  logic            reg_write_d;
  logic            transfer;

  // x0 is never a bypass target, even if writeback reports it.
  assign rs1_fwd = (bus.fwd_valid && (bus.fwd_rd == rs1_idx) && (bus.fwd_rd != '0))
                   ? bus.fwd_data : bus.rs1_data;
  assign rs2_fwd = (bus.fwd_valid && (bus.fwd_rd == rs2_idx) && (bus.fwd_rd != '0))
                   ? bus.fwd_data : bus.rs2_data;

  always_comb begin
    alu_x_d = '0;
    case (ctrl.x_sel)
      X_RS1:   alu_x_d = rs1_fwd;
      X_PC:    alu_x_d = bus.pc;
      default: alu_x_d = '0;
    endcase
  end

  always_comb begin
    alu_y_d = '0;
    case (ctrl.y_sel)
      Y_RS2:   alu_y_d = rs2_fwd;
      Y_IMM:   alu_y_d = bus.imm;
      default: alu_y_d = '0;
    endcase
  end

  assign reg_write_d = ctrl.wb_en && (rd_idx != '0);

  logic                out_valid_q;
  alu_op_e             alu_op_q;
  logic [XLEN-1:0]     alu_x_q;
  logic [XLEN-1:0]     alu_y_q;
  logic [XLEN-1:0]     store_data_q;
  logic [REG_ADDR-1:0] rd_q;
  logic                reg_write_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic                branch_q;
  logic                illegal_q;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign transfer     = bus.in_valid && bus.in_ready;

  // Flush wins over an accepted instruction: both held and offered entries are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (transfer) begin
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op_q     <= ALU_AND;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (transfer && !bus.flush) begin
      alu_op_q     <= ctrl.alu_op;
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      store_data_q <= rs2_fwd;
      rd_q         <= rd_idx;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= ctrl.mem_read;
      mem_write_q  <= ctrl.mem_write;
      branch_q     <= ctrl.branch;
      illegal_q    <= ctrl.illegal;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_x      = alu_x_q;
  assign bus.alu_y      = alu_y_q;
  assign bus.store_data = store_data_q;
  assign bus.rd         = rd_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.branch     = branch_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed cases then randomized traffic against a
// mnemonic-level reference model of the stage.
module tb_ex_issue_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ex_issue_stage_if bus ();

  ex_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
  } exp_t;

  exp_t exp_q;
  logic mv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pcv,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] im, input logic fv,
                                 input logic [4:0] frd, input logic [31:0] fd);
    exp_t e;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        writes;
    opc = ins[6:0];
    f3  = ins[14:12];
    a = (fv && frd != 0 && frd == ins[19:15]) ? fd : r1;
    b = (fv && frd != 0 && frd == ins[24:20]) ? fd : r2;
    e.op = 4'b0010; e.x = 0; e.y = 0; e.sd = b; e.rd = ins[11:7];
    e.mr = 0; e.mw = 0; e.br = 0; e.ill = 1; writes = 0;
    if ((opc == 7'b0110011 || opc == 7'b0010011) && (f3 inside {3'd0, 3'd7, 3'd6, 3'd2})) begin
      e.ill = 0; writes = 1; e.x = a;
      e.y = (opc == 7'b0110011) ? b : im;
      if (f3 == 3'd7)      e.op = 4'b0000;
      else if (f3 == 3'd6) e.op = 4'b0001;
      else if (f3 == 3'd2) e.op = 4'b0111;
      else                 e.op = (opc == 7'b0110011 && ins[30]) ? 4'b0110 : 4'b0010;
    end else if (opc == 7'b0000011) begin
      e.ill = 0; writes = 1; e.x = a; e.y = im; e.mr = 1;
    end else if (opc == 7'b0100011) begin
      e.ill = 0; e.x = a; e.y = im; e.mw = 1;
    end else if (opc == 7'b1100011 && f3 <= 3'd1) begin
      e.ill = 0; e.x = a; e.y = b; e.op = 4'b0110; e.br = 1;
    end else if (opc == 7'b0110111) begin
      e.ill = 0; writes = 1; e.y = im;
    end else if (opc == 7'b0010111) begin
      e.ill = 0; writes = 1; e.x = pcv; e.y = im;
    end
    e.rw = writes && (e.rd != 0);
    return e;
  endfunction

  task automatic check_outputs();
    chk("out_valid", bus.out_valid, mv);
    if (mv) begin
      chk("alu_op", bus.alu_op, exp_q.op);
      chk("alu_x", bus.alu_x, exp_q.x);
      chk("alu_y", bus.alu_y, exp_q.y);
      chk("store_data", bus.store_data, exp_q.sd);
      chk("rd", bus.rd, exp_q.rd);
      chk("reg_write", bus.reg_write, exp_q.rw);
      chk("mem_read", bus.mem_read, exp_q.mr);
      chk("mem_write", bus.mem_write, exp_q.mw);
      chk("branch", bus.branch, exp_q.br);
      chk("illegal", bus.illegal, exp_q.ill);
    end
  endtask

  task automatic step(input logic iv, input logic orr, input logic fl,
                      input logic [31:0] ins, input logic [31:0] pcv,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                      input logic fv, input logic [4:0] frd, input logic [31:0] fd);
    @(negedge clk);
    bus.in_valid = iv; bus.out_ready = orr; bus.flush = fl;
    bus.instr = ins; bus.pc = pcv; bus.rs1_data = r1; bus.rs2_data = r2; bus.imm = im;
    bus.fwd_valid = fv; bus.fwd_rd = frd; bus.fwd_data = fd;
    #1;
    chk("in_ready", bus.in_ready, !mv || orr);
    if (fl) mv = 0;
    else if (iv && (!mv || orr)) begin
      mv = 1;
      exp_q = model(ins, pcv, r1, r2, im, fv, frd, fd);
    end else if (orr) mv = 0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d, input logic [6:0] opc);
    return {f7, s2, s1, f3, d, opc};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [10];
    logic [31:0] ins;
    opcs = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000};
    ins = $urandom;
    ins[6:0]   = opcs[$urandom_range(0, 9)];
    if (ins[6:0] == 7'b0000000) ins[6:0] = 7'($urandom);
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  localparam logic [6:0] OP = 7'b0110011;

  initial begin
    checks = 0; errors = 0; mv = 0;
    reset = 1;
    bus.in_valid = 0; bus.out_ready = 0; bus.flush = 0; bus.instr = 0; bus.pc = 0;
    bus.rs1_data = 0; bus.rs2_data = 0; bus.imm = 0;
    bus.fwd_valid = 0; bus.fwd_rd = 0; bus.fwd_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_alu_x", bus.alu_x, 0);
    chk("rst_reg_write", bus.reg_write, 0);
    chk("rst_illegal", bus.illegal, 0);
    @(negedge clk);
    reset = 0;

    step(1, 1, 0, r_ins(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, OP), 0, 5, 7, 0, 0, 0, 0);
    chk("add_op", bus.alu_op, 4'b0010);
    chk("add_x", bus.alu_x, 5);
    chk("add_y", bus.alu_y, 7);
    chk("add_rd", bus.rd, 3);
    chk("add_rw", bus.reg_write, 1);

    step(1, 1, 0, r_ins(7'b0100000, 5'd2, 5'd1, 3'd0, 5'd3, OP), 0, 5, 7, 0, 0, 0, 0);
    chk("sub_op", bus.alu_op, 4'b0110);

    step(1, 1, 0, {12'hFFF, 5'd0, 3'd0, 5'd1, 7'b0010011}, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0);
    chk("addi_y", bus.alu_y, 32'hFFFF_FFFF);
    chk("addi_x", bus.alu_x, 0);

    step(1, 1, 0, r_ins(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, OP), 0, 9, 1, 0, 1, 5'd1, 42);
    chk("fwd_hit_x", bus.alu_x, 42);
    step(1, 1, 0, r_ins(7'd0, 5'd2, 5'd0, 3'd0, 5'd3, OP), 0, 9, 1, 0, 1, 5'd0, 42);
    chk("fwd_x0_x", bus.alu_x, 9);

    step(1, 1, 0, r_ins(7'd0, 5'd2, 5'd1, 3'd7, 5'd4, OP), 0, 32'hF0F0, 32'h0FF0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, r_ins(7'd0, 5'd2, 5'd1, 3'd6, 5'd5, OP), 0, 32'h100, 32'h001, 0, 0, 0, 0);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_hold_op", bus.alu_op, 4'b0000);
    end
    step(1, 1, 0, r_ins(7'd0, 5'd2, 5'd1, 3'd6, 5'd5, OP), 0, 32'h100, 32'h001, 0, 0, 0, 0);
    chk("release_op", bus.alu_op, 4'b0001);
    chk("release_rd", bus.rd, 5);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("drain_valid", bus.out_valid, 0);

    step(1, 1, 0, r_ins(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, OP), 0, 1, 2, 0, 0, 0, 0);
    step(1, 0, 1, r_ins(7'd0, 5'd2, 5'd1, 3'd0, 5'd6, OP), 0, 1, 2, 0, 0, 0, 0);
    chk("flush_valid", bus.out_valid, 0);

    step(1, 1, 0, r_ins(7'd0, 5'd3, 5'd2, 3'd4, 5'd1, OP), 0, 1, 2, 0, 0, 0, 0);
    chk("xor_illegal", bus.illegal, 1);
    chk("xor_rw", bus.reg_write, 0);
    step(1, 1, 0, r_ins(7'd0, 5'd2, 5'd1, 3'd0, 5'd0, OP), 0, 1, 2, 0, 0, 0, 0);
    chk("x0_rw", bus.reg_write, 0);
    step(1, 1, 0, {20'h12345, 5'd5, 7'b0110111}, 32'h40, 77, 0, 32'h1234_5000, 0, 0, 0);
    chk("lui_x", bus.alu_x, 0);
    chk("lui_y", bus.alu_y, 32'h1234_5000);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           rand_instr(), $urandom, $urandom, $urandom, $urandom,
           1'($urandom), 5'($urandom_range(0, 3)), $urandom);
    end

    step(1, 1, 0, r_ins(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, OP), 0, 3, 4, 0, 0, 0, 0);
    step(1, 0, 0, r_ins(7'd0, 5'd2, 5'd1, 3'd2, 5'd3, OP), 0, 3, 4, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1; bus.in_valid = 1; bus.out_ready = 0;
    @(posedge clk);
    #1;
    mv = 0;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_alu_op", bus.alu_op, 0);
    chk("midrst_alu_x", bus.alu_x, 0);
    chk("midrst_rd", bus.rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
